// File: rtl/mips_mem_pkg.sv
// Shared memory-subsystem constants for the MIPS data path.
// The store buffer takes its default geometry from here.
package mips_mem_pkg;
  localparam int WORD_W   = 32;
  localparam int ADDR_W   = 32;
  localparam int SB_DEPTH = 4;
endpackage

// File: rtl/sb_match.sv
// Combinational youngest-match search over the store buffer entries.
// Reports whether a load address hits a valid entry and which slot is the youngest hit.
module sb_match
  import mips_mem_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = mips_mem_pkg::ADDR_W,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]  valid,
  input  logic [ADDR_W-1:0] addrs [DEPTH],
  input  logic [PTR_W-1:0]  tail,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              hit,
  output logic [PTR_W-1:0]  idx
);

  logic [PTR_W-1:0] pos;

  // Walk from oldest slot (tail - DEPTH) toward youngest (tail - 1); last match wins.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    pos = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      pos = tail - PTR_W'(k);
      if (valid[pos] && (addrs[pos] == ld_addr)) begin
        hit = 1'b1;
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Circular store buffer between the MEM stage and data memory.
// Drains stores in program order and forwards data of the youngest matching store to loads.
module store_buffer
  import mips_mem_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int DATA_W = WORD_W,
  parameter int ADDR_W = mips_mem_pkg::ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     st_valid,
  input  logic [ADDR_W-1:0]        st_addr,
  input  logic [DATA_W-1:0]        st_data,
  output logic                     st_ready,
  input  logic                     ld_valid,
  input  logic [ADDR_W-1:0]        ld_addr,
  output logic                     ld_hit,
  output logic [DATA_W-1:0]        ld_data,
  input  logic                     mem_grant,
  output logic                     mem_write,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [DEPTH-1:0]  valid;
  logic [DEPTH-1:0]  valid_next;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [CNT_W-1:0]  count_next;
  logic              push;
  logic              pop;
  logic              match_hit;
  logic [PTR_W-1:0]  match_idx;

  assign st_ready  = (count != CNT_W'(DEPTH));
  assign push      = st_valid && st_ready;
  assign mem_write = !empty && mem_grant;
  assign pop       = mem_write;
  assign mem_addr  = addr_q[head];
  assign mem_wdata = data_q[head];

  always_comb begin
    valid_next = valid;
    if (pop)  valid_next[head] = 1'b0;
    if (push) valid_next[tail] = 1'b1;
    count_next = count + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      valid <= '0;
      count <= '0;
      empty <= 1'b1;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      valid <= valid_next;
      count <= count_next;
      empty <= (count_next == '0);
    end
  end

  // Payload storage has no reset; the valid bits alone decide what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= st_addr;
      data_q[tail] <= st_data;
    end
  end

  sb_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_match (
    .valid   (valid),
    .addrs   (addr_q),
    .tail    (tail),
    .ld_addr (ld_addr),
    .hit     (match_hit),
    .idx     (match_idx)
  );

  assign ld_hit  = ld_valid && match_hit;
  assign ld_data = ld_hit ? data_q[match_idx] : '0;

endmodule

// File: tb/tb_store_buffer.sv
// Directed testbench for store_buffer: reset, drain, full, forwarding, wrap and mid-drain reset.
// A negedge-sampled memory log records every write the buffer issues.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        mem_grant;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  count;
  logic        empty;

  int n_checks = 0;
  int n_fails  = 0;

  logic [31:0] log_addr [$];
  logic [31:0] log_data [$];

  store_buffer dut (
    .clk       (clk),
    .rst       (rst),
    .st_valid  (st_valid),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_ready  (st_ready),
    .ld_valid  (ld_valid),
    .ld_addr   (ld_addr),
    .ld_hit    (ld_hit),
    .ld_data   (ld_data),
    .mem_grant (mem_grant),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .count     (count),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  // Data memory model: captures the write on the negedge of the granting cycle.
  always @(negedge clk) begin
    if (mem_write) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0;
    ld_valid = 1'b1; ld_addr = 32'h0; mem_grant = 1'b1;
    #1;
    n_checks++; if (st_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL reset_st_ready: got %b expected 1", st_ready); end
    n_checks++; if (empty !== 1'b1) begin n_fails++; $display("[TB] FAIL reset_empty: got %b expected 1", empty); end
    n_checks++; if (count !== 3'd0) begin n_fails++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (mem_write !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_mem_write: got %b expected 0", mem_write); end
    n_checks++; if (ld_hit !== 1'b0 || ld_data !== 32'h0) begin n_fails++; $display("[TB] FAIL reset_ld: got hit=%b data=%h expected 0/0", ld_hit, ld_data); end
    tick();
    rst = 1'b0; ld_valid = 1'b0; mem_grant = 1'b0;
    tick();
  endtask

  task automatic test_single_drain();
    clear_log();
    st_valid = 1'b1; st_addr = 32'h4; st_data = 32'hAAAA0001; mem_grant = 1'b0;
    tick();
    st_valid = 1'b0;
    n_checks++; if (count !== 3'd1 || empty !== 1'b0) begin n_fails++; $display("[TB] FAIL single_count: got count=%0d empty=%b expected 1/0", count, empty); end
    n_checks++; if (mem_write !== 1'b0) begin n_fails++; $display("[TB] FAIL single_no_grant: got mem_write=%b expected 0", mem_write); end
    mem_grant = 1'b1;
    #1;
    n_checks++; if (mem_write !== 1'b1 || mem_addr !== 32'h4 || mem_wdata !== 32'hAAAA0001) begin n_fails++; $display("[TB] FAIL single_write: got we=%b addr=%h data=%h expected 1/00000004/aaaa0001", mem_write, mem_addr, mem_wdata); end
    tick();
    mem_grant = 1'b0;
    n_checks++; if (count !== 3'd0 || empty !== 1'b1) begin n_fails++; $display("[TB] FAIL single_drained: got count=%0d empty=%b expected 0/1", count, empty); end
    n_checks++; if (log_addr.size() != 1) begin n_fails++; $display("[TB] FAIL single_log_size: got %0d expected 1", log_addr.size()); end
  endtask

  task automatic test_full();
    clear_log();
    mem_grant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      st_valid = 1'b1; st_addr = 32'h100 + 32'(4 * i); st_data = 32'(i + 1);
      tick();
    end
    n_checks++; if (count !== 3'd4 || st_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL full_state: got count=%0d st_ready=%b expected 4/0", count, st_ready); end
    st_addr = 32'h200; st_data = 32'hDEAD;
    tick();
    n_checks++; if (count !== 3'd4) begin n_fails++; $display("[TB] FAIL full_push_ignored: got count=%0d expected 4", count); end
    st_addr = 32'h300; st_data = 32'hBEEF; mem_grant = 1'b1;
    #1;
    n_checks++; if (st_ready !== 1'b0 || mem_write !== 1'b1 || mem_addr !== 32'h100) begin n_fails++; $display("[TB] FAIL full_push_pop: got st_ready=%b we=%b addr=%h expected 0/1/00000100", st_ready, mem_write, mem_addr); end
    tick();
    st_valid = 1'b0;
    n_checks++; if (count !== 3'd3 || st_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL full_after_pop: got count=%0d st_ready=%b expected 3/1", count, st_ready); end
    tick(); tick(); tick();
    mem_grant = 1'b0;
    n_checks++; if (count !== 3'd0) begin n_fails++; $display("[TB] FAIL full_drained: got count=%0d expected 0", count); end
    n_checks++; if (log_addr.size() != 4) begin n_fails++; $display("[TB] FAIL full_log_size: got %0d expected 4", log_addr.size()); end
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      n_checks++;
      if (log_addr[i] !== 32'h100 + 32'(4 * i) || log_data[i] !== 32'(i + 1)) begin
        n_fails++; $display("[TB] FAIL full_order[%0d]: got %h/%h expected %h/%h", i, log_addr[i], log_data[i], 32'h100 + 32'(4 * i), 32'(i + 1));
      end
    end
  endtask

  task automatic test_forwarding();
    mem_grant = 1'b0;
    st_valid = 1'b1; st_addr = 32'h8; st_data = 32'h11;
    tick();
    st_data = 32'h22;
    tick();
    st_valid = 1'b0; ld_valid = 1'b1; ld_addr = 32'h8;
    #1;
    n_checks++; if (ld_hit !== 1'b1 || ld_data !== 32'h22) begin n_fails++; $display("[TB] FAIL fwd_youngest: got hit=%b data=%h expected 1/00000022", ld_hit, ld_data); end
    ld_addr = 32'hC;
    #1;
    n_checks++; if (ld_hit !== 1'b0 || ld_data !== 32'h0) begin n_fails++; $display("[TB] FAIL fwd_miss: got hit=%b data=%h expected 0/0", ld_hit, ld_data); end
    ld_valid = 1'b0; ld_addr = 32'h8;
    #1;
    n_checks++; if (ld_hit !== 1'b0 || ld_data !== 32'h0) begin n_fails++; $display("[TB] FAIL fwd_no_valid: got hit=%b data=%h expected 0/0", ld_hit, ld_data); end
    ld_valid = 1'b1; mem_grant = 1'b1;
    tick();
    n_checks++; if (ld_hit !== 1'b1 || ld_data !== 32'h22 || mem_write !== 1'b1) begin n_fails++; $display("[TB] FAIL fwd_popping_entry: got hit=%b data=%h we=%b expected 1/00000022/1", ld_hit, ld_data, mem_write); end
    tick();
    n_checks++; if (count !== 3'd0 || ld_hit !== 1'b0 || ld_data !== 32'h0) begin n_fails++; $display("[TB] FAIL fwd_after_drain: got count=%0d hit=%b data=%h expected 0/0/0", count, ld_hit, ld_data); end
    ld_valid = 1'b0; mem_grant = 1'b0;
  endtask

  task automatic test_back_to_back();
    clear_log();
    mem_grant = 1'b0;
    for (int i = 0; i < 2; i++) begin
      st_valid = 1'b1; st_addr = 32'h40 + 32'(4 * i); st_data = 32'hA0 + 32'(i);
      tick();
    end
    n_checks++; if (count !== 3'd2) begin n_fails++; $display("[TB] FAIL b2b_start: got count=%0d expected 2", count); end
    mem_grant = 1'b1;
    for (int i = 2; i < 6; i++) begin
      st_valid = 1'b1; st_addr = 32'h40 + 32'(4 * i); st_data = 32'hA0 + 32'(i);
      tick();
      n_checks++; if (count !== 3'd2) begin n_fails++; $display("[TB] FAIL b2b_count[%0d]: got %0d expected 2", i, count); end
    end
    st_valid = 1'b0;
    tick(); tick();
    mem_grant = 1'b0;
    n_checks++; if (count !== 3'd0 || empty !== 1'b1) begin n_fails++; $display("[TB] FAIL b2b_drained: got count=%0d empty=%b expected 0/1", count, empty); end
    n_checks++; if (log_addr.size() != 6) begin n_fails++; $display("[TB] FAIL b2b_log_size: got %0d expected 6", log_addr.size()); end
    for (int i = 0; i < 6 && i < log_addr.size(); i++) begin
      n_checks++;
      if (log_addr[i] !== 32'h40 + 32'(4 * i) || log_data[i] !== 32'hA0 + 32'(i)) begin
        n_fails++; $display("[TB] FAIL b2b_order[%0d]: got %h/%h expected %h/%h", i, log_addr[i], log_data[i], 32'h40 + 32'(4 * i), 32'hA0 + 32'(i));
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    mem_grant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      st_valid = 1'b1; st_addr = 32'h80 + 32'(4 * i); st_data = 32'hC0 + 32'(i);
      tick();
    end
    st_valid = 1'b0;
    n_checks++; if (count !== 3'd3) begin n_fails++; $display("[TB] FAIL rstmid_count: got %0d expected 3", count); end
    clear_log();
    mem_grant = 1'b1;
    #1;
    n_checks++; if (mem_write !== 1'b1) begin n_fails++; $display("[TB] FAIL rstmid_pre_write: got %b expected 1", mem_write); end
    rst = 1'b1;
    #1;
    n_checks++; if (count !== 3'd0 || mem_write !== 1'b0 || empty !== 1'b1 || st_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL rstmid_async: got count=%0d we=%b empty=%b rdy=%b expected 0/0/1/1", count, mem_write, empty, st_ready); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (mem_write !== 1'b0) begin n_fails++; $display("[TB] FAIL rstmid_no_write[%0d]: got %b expected 0", i, mem_write); end
    end
    n_checks++; if (log_addr.size() != 0) begin n_fails++; $display("[TB] FAIL rstmid_log: got %0d writes expected 0", log_addr.size()); end
    mem_grant = 1'b0;
  endtask

  task automatic test_no_bypass();
    mem_grant = 1'b0;
    st_valid = 1'b1; st_addr = 32'h10; st_data = 32'h5;
    ld_valid = 1'b1; ld_addr = 32'h10;
    #1;
    n_checks++; if (ld_hit !== 1'b0 || ld_data !== 32'h0) begin n_fails++; $display("[TB] FAIL nobypass_same: got hit=%b data=%h expected 0/0", ld_hit, ld_data); end
    tick();
    st_valid = 1'b0;
    #1;
    n_checks++; if (ld_hit !== 1'b1 || ld_data !== 32'h5 || count !== 3'd1) begin n_fails++; $display("[TB] FAIL nobypass_next: got hit=%b data=%h count=%0d expected 1/00000005/1", ld_hit, ld_data, count); end
    ld_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_drain();
    test_full();
    test_forwarding();
    test_back_to_back();
    test_reset_mid_drain();
    test_no_bypass();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
